mem_bist_ctrl: RTL and testbench



---
 rtl/mem_bist_pkg.sv | 40 ++++
 rtl/mem_bist_errlog.sv | 80 ++++++++
 rtl/mem_bist_ctrl.sv | 171 +++++++++++++++++
 tb/tb_mem_bist_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_bist_pkg.sv
// mem_bist_pkg: shared types, default widths and the data pattern generator
// for the memory BIST controller.
//   bist_state_e   : controller states
//   bist_pattern_e : selectable data patterns (matches pattern_sel encoding)
//   bist_pattern() : pattern value for an address, 64 bits wide; callers
//                    truncate to their data width.
package mem_bist_pkg;

  localparam int BIST_ADDR_W = 5;
  localparam int BIST_DATA_W = 8;

  typedef enum logic [2:0] {
    BIST_IDLE  = 3'd0,
    BIST_WRITE = 3'd1,
    BIST_READ  = 3'd2,
    BIST_DRAIN = 3'd3,
    BIST_DONE  = 3'd4
  } bist_state_e;

  typedef enum logic [1:0] {
    PAT_ZERO    = 2'd0,
    PAT_ONES    = 2'd1,
    PAT_ADDR    = 2'd2,
    PAT_CHECKER = 2'd3
  } bist_pattern_e;

  function automatic logic [63:0] bist_pattern(input bist_pattern_e pattern,
                                               input logic [63:0] addr);
    logic [63:0] val;
    case (pattern)
      PAT_ZERO:    val = '0;
      PAT_ONES:    val = '1;
      PAT_ADDR:    val = addr;
      PAT_CHECKER: val = addr[0] ? {32{2'b01}} : {32{2'b10}};
      default:     val = '0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/mem_bist_errlog.sv
// mem_bist_errlog: error counter and first-mismatch capture for the BIST.
// Optional feature macro: MEM_BIST_ERRLOG_EN builds the first-error capture
// registers; without it first_err_addr/first_err_data are tied to 0.
// Ports:
//   clk, rst        : clock, async active-high reset
//   clr             : clear all results (run accepted)
//   err_valid       : a compared location mismatched this cycle
//   err_addr/data   : address and read data of that location
//   err_count       : mismatches since clr
//   first_err_addr  : address of first mismatch since clr
//   first_err_data  : read data of first mismatch since clr
module mem_bist_errlog
  import mem_bist_pkg::*;
#(
  parameter int ADDR_W = BIST_ADDR_W,
  parameter int DATA_W = BIST_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              err_valid,
  input  logic [ADDR_W-1:0] err_addr,
  input  logic [DATA_W-1:0] err_data,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data
);

  // One extra bit: every location can fail, so 2**ADDR_W must be representable.
  logic [ADDR_W:0] err_count_q, err_count_d;

  always_comb begin
    err_count_d = err_count_q;
    if (clr)            err_count_d = '0;
    else if (err_valid) err_count_d = err_count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_count_q <= '0;
    else     err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;

`ifdef MEM_BIST_ERRLOG_EN
  logic [ADDR_W-1:0] first_err_addr_q, first_err_addr_d;
  logic [DATA_W-1:0] first_err_data_q, first_err_data_d;

  always_comb begin
    first_err_addr_d = first_err_addr_q;
    first_err_data_d = first_err_data_q;
    if (clr) begin
      first_err_addr_d = '0;
      first_err_data_d = '0;
    end else if (err_valid && (err_count_q == '0)) begin
      first_err_addr_d = err_addr;
      first_err_data_d = err_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_err_addr_q <= '0;
      first_err_data_q <= '0;
    end else begin
      first_err_addr_q <= first_err_addr_d;
      first_err_data_q <= first_err_data_d;
    end
  end

  assign first_err_addr = first_err_addr_q;
  assign first_err_data = first_err_data_q;
`else
  logic unused_errlog;
  assign unused_errlog  = ^{err_addr, err_data};
  assign first_err_addr = '0;
  assign first_err_data = '0;
`endif

endmodule

// File: rtl/mem_bist_ctrl.sv
// mem_bist_ctrl: memory BIST initiator. Writes a pattern to every location,
// reads every location back (one per cycle, pipelined compare) and reports
// pass/fail with an error count.
// Optional feature macro: MEM_BIST_ERRLOG_EN (first-error capture, see
// mem_bist_errlog).
// Ports:
//   clk, rst                 : clock, async active-high reset
//   start, pattern_sel       : run request and pattern, sampled in IDLE
//   busy, done, pass         : run status; done is a one-cycle pulse
//   err_count, first_err_*   : results of the last run
//   mem_read/mem_write       : memory strobes (never both high)
//   mem_addr/mem_wdata       : memory address / write data (0 when idle)
//   mem_rdata                : memory read data, valid one cycle after read
//
// state | meaning
// IDLE  | waiting for start
// WRITE | writing pattern(addr) to every address
// READ  | issuing reads, comparing the previous address each cycle
// DRAIN | comparing the last address, no strobe
// DONE  | done pulse, pass valid
module mem_bist_ctrl
  import mem_bist_pkg::*;
#(
  parameter int ADDR_W = BIST_ADDR_W,
  parameter int DATA_W = BIST_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        pattern_sel,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  bist_state_e       state_q, state_d;
  bist_pattern_e     pattern_q, pattern_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              cmp_valid_q, cmp_valid_d;
  logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
  logic [DATA_W-1:0] cmp_exp_q, cmp_exp_d;

  logic              run_accept;
  logic              mismatch;

  assign run_accept = (state_q == BIST_IDLE) && start;
  assign mismatch   = cmp_valid_q && (mem_rdata != cmp_exp_q);

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    cnt_d     = cnt_q;
    pass_d    = pass_q;

    case (state_q)
      BIST_IDLE: begin
        if (start) begin
          state_d   = BIST_WRITE;
          pattern_d = bist_pattern_e'(pattern_sel);
          cnt_d     = '0;
          pass_d    = 1'b0;
        end
      end
      BIST_WRITE: begin
        cnt_d = cnt_q + 1'b1;  // wraps to 0 for the read pass
        if (cnt_q == LAST_ADDR) state_d = BIST_READ;
      end
      BIST_READ: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) state_d = BIST_DRAIN;
      end
      BIST_DRAIN: begin
        // The last compare lands on this edge, so fold it in directly.
        state_d = BIST_DONE;
        pass_d  = (err_count == '0) && !mismatch;
      end
      BIST_DONE: begin
        state_d = BIST_IDLE;
      end
      default: begin
        state_d = BIST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    mem_write_d = (state_d == BIST_WRITE);
    mem_read_d  = (state_d == BIST_READ);
    mem_addr_d  = (mem_write_d || mem_read_d) ? cnt_d : '0;
    mem_wdata_d = mem_write_d ? DATA_W'(bist_pattern(pattern_d, 64'(cnt_d))) : '0;
    busy_d      = (state_d != BIST_IDLE);
    done_d      = (state_d == BIST_DONE);

    // Compare stage trails the read strobe by one cycle, matching memory latency.
    cmp_valid_d = mem_read_q;
    cmp_addr_d  = mem_addr_q;
    cmp_exp_d   = DATA_W'(bist_pattern(pattern_q, 64'(mem_addr_q)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= BIST_IDLE;
      pattern_q   <= PAT_ZERO;
      cnt_q       <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      cmp_valid_q <= 1'b0;
      cmp_addr_q  <= '0;
      cmp_exp_q   <= '0;
    end else begin
      state_q     <= state_d;
      pattern_q   <= pattern_d;
      cnt_q       <= cnt_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_addr_q  <= cmp_addr_d;
      cmp_exp_q   <= cmp_exp_d;
    end
  end

  mem_bist_errlog #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_errlog (
    .clk           (clk),
    .rst           (rst),
    .clr           (run_accept),
    .err_valid     (mismatch),
    .err_addr      (cmp_addr_q),
    .err_data      (mem_rdata),
    .err_count     (err_count),
    .first_err_addr(first_err_addr),
    .first_err_data(first_err_data)
  );

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
module tb_mem_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] pattern_sel = 2'd0;
  logic       busy, done, pass;
  logic [5:0] err_count;
  logic [4:0] first_err_addr;
  logic [7:0] first_err_data;
  logic       mem_read, mem_write;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 8'h00;

  int n_vec = 0;
  int n_err = 0;

  // Memory fault injection: stuck-at-0 mask on every readback, plus an XOR
  // corruption applied to one address on readback.
  logic [7:0] stuck_mask   = 8'h00;
  logic [7:0] corrupt_xor  = 8'h00;
  logic [4:0] corrupt_addr = 5'd0;
  logic [7:0] mem [32];

  bit overlap_seen = 1'b0;
  bit bad_idle     = 1'b0;

  always #5 clk = ~clk;

  mem_bist_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .pattern_sel   (pattern_sel),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .first_err_addr(first_err_addr),
    .first_err_data(first_err_data),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
    if (mem_read)
      mem_rdata <= (mem[mem_addr] & ~stuck_mask) ^
                   ((mem_addr == corrupt_addr) ? corrupt_xor : 8'h00);
  end

  always @(negedge clk) begin
    if (mem_read && mem_write) overlap_seen = 1'b1;
    if (!mem_read && !mem_write && (mem_addr != 5'd0 || mem_wdata != 8'h00)) bad_idle = 1'b1;
  end

  function automatic logic [7:0] ref_pat(input logic [1:0] p, input int a);
    case (p)
      2'd0:    return 8'h00;
      2'd1:    return 8'hFF;
      2'd2:    return 8'(a);
      default: return (a % 2 == 1) ? 8'h55 : 8'hAA;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One run: pulse_k>0 pulses start in cycle E+pulse_k; rst_k>0 asserts reset
  // in cycle E+rst_k and releases it five cycles later.
  task automatic run(input logic [1:0] pat, input logic [7:0] sm, input logic [7:0] cx,
                     input int ca, input int pulse_k, input int rst_k);
    int done_k, busy_off_k, ndone, nwr, nrd, bad_wr, bad_rd;
    int exp_cnt, exp_fa, exp_fd;
    logic pass_at_done;
    logic [7:0] w, r;
    done_k = 0; busy_off_k = 0; ndone = 0; nwr = 0; nrd = 0; bad_wr = 0; bad_rd = 0;
    pass_at_done = 1'b0;
    stuck_mask = sm; corrupt_xor = cx; corrupt_addr = 5'(ca);

    exp_cnt = 0; exp_fa = 0; exp_fd = 0;
    for (int a = 0; a < 32; a++) begin
      w = ref_pat(pat, a);
      r = (w & ~sm) ^ ((a == ca) ? cx : 8'h00);
      if (r != w) begin
        if (exp_cnt == 0) begin exp_fa = a; exp_fd = int'(r); end
        exp_cnt++;
      end
    end
`ifndef MEM_BIST_ERRLOG_EN
    exp_fa = 0; exp_fd = 0;
`endif

    @(negedge clk);
    start = 1'b1; pattern_sel = pat;
    @(posedge clk);
    #1;
    start = 1'b0;
    pattern_sel = 2'($urandom);
    chk("pass_cleared", 32'(pass), 0);
    chk("errcnt_cleared", 32'(err_count), 0);
    chk("busy_after_start", 32'(busy), 1);

    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (pulse_k != 0 && k == pulse_k) start = 1'b1;
      if (pulse_k != 0 && k == pulse_k + 1) start = 1'b0;
      if (rst_k != 0 && k == rst_k) begin
        rst = 1'b1;
        #1;
        chk("rst_read_drop", 32'(mem_read), 0);
        chk("rst_busy_drop", 32'(busy), 0);
      end
      if (rst_k != 0 && k == rst_k + 5) rst = 1'b0;
      if (mem_write) begin
        nwr++;
        if (k > 32 || mem_addr != 5'(k - 1) || mem_wdata != ref_pat(pat, k - 1)) bad_wr++;
      end
      if (mem_read) begin
        nrd++;
        if (k < 33 || k > 64 || mem_addr != 5'(k - 33)) bad_rd++;
      end
      if (done) begin
        ndone++;
        if (done_k == 0) begin done_k = k; pass_at_done = pass; end
      end
      if (!busy && busy_off_k == 0) busy_off_k = k;
    end

    if (rst_k == 0) begin
      chk("write_count", 32'(nwr), 32);
      chk("read_count", 32'(nrd), 32);
      chk("write_addr_data", 32'(bad_wr), 0);
      chk("read_addr", 32'(bad_rd), 0);
      chk("done_cycle", 32'(done_k), 66);
      chk("done_pulses", 32'(ndone), 1);
      chk("busy_fall", 32'(busy_off_k), 67);
      chk("pass_at_done", 32'(pass_at_done), (exp_cnt == 0) ? 1 : 0);
      chk("pass_hold", 32'(pass), (exp_cnt == 0) ? 1 : 0);
      chk("err_count", 32'(err_count), 32'(exp_cnt));
      chk("first_err_addr", 32'(first_err_addr), 32'(exp_fa));
      chk("first_err_data", 32'(first_err_data), 32'(exp_fd));
    end else begin
      chk("rst_no_done", 32'(ndone), 0);
      chk("rst_busy_idle", 32'(busy), 0);
      chk("rst_pass", 32'(pass), 0);
      chk("rst_err_count", 32'(err_count), 0);
      chk("rst_no_strobe", 32'(mem_read | mem_write), 0);
    end
  endtask

  initial begin
    int dq[$];
    int c;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_pass", 32'(pass), 0);
    chk("reset_err_count", 32'(err_count), 0);
    chk("reset_first_addr", 32'(first_err_addr), 0);
    chk("reset_first_data", 32'(first_err_data), 0);
    chk("reset_mem_read", 32'(mem_read), 0);
    chk("reset_mem_write", 32'(mem_write), 0);
    chk("reset_mem_addr", 32'(mem_addr), 0);
    chk("reset_mem_wdata", 32'(mem_wdata), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run(2'd2, 8'h00, 8'h00, 0, 0, 0);
    run(2'd3, 8'h00, 8'h00, 0, 0, 0);
    run(2'd1, 8'h08, 8'h00, 0, 0, 0);
    run(2'd2, 8'h00, 8'h40, 31, 0, 0);
    run(2'($urandom), 8'h00, 8'h00, 0, 45, 0);
    run(2'd0, 8'h00, 8'h00, 0, 0, 40);
    for (int i = 0; i < 4; i++)
      run(2'($urandom), ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00,
          8'($urandom), int'($urandom_range(0, 31)), 0, 0);

    stuck_mask = 8'h00; corrupt_xor = 8'h00;
    @(negedge clk);
    start = 1'b1; pattern_sel = 2'd3;
    c = 0;
    for (int k = 0; k < 210; k++) begin
      @(negedge clk);
      c++;
      if (done) dq.push_back(c);
    end
    start = 1'b0;
    repeat (80) @(negedge clk);
    chk("b2b_done_count", 32'(dq.size()), 3);
    for (int i = 1; i < dq.size(); i++)
      chk("b2b_done_spacing", 32'(dq[i] - dq[i-1]), 67);
    chk("b2b_pass", 32'(pass), 1);

    chk("strobe_overlap", 32'(overlap_seen), 0);
    chk("idle_bus_zero", 32'(bad_idle), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
